// File: rtl/ehl_ahb_matrix_slave_port.sv
// ---------------------------------------------------------------------------
// ehl_ahb_matrix_slave_port
// Per-slave output stage of an AHB bus matrix. Arbitrates among MNUM masters
// (round-robin, bursts keep the grant), muxes the winner's address phase to
// the slave, steers write data from the data-phase owner and returns the
// slave response plus a per-master HREADY contribution.
//
// Ports
//   hclk, hresetn                  clock, async active-low reset
//   im_haddr/htrans/hwrite/hsize/  per-master address phase, master m in
//   im_hburst/hprot/hwdata         slice m (htrans is IDLE if not decoded here)
//   om_hrdata, om_hresp            slave read data / response pass-through
//   om_hready                      per-master ready (stalls losers and owner)
//   os_haddr ... os_hprot, os_hsel muxed address phase to the slave
//   os_hwdata                      write data of the data-phase owner
//   is_hrdata, is_hready, is_hresp slave return path
// ---------------------------------------------------------------------------
module ehl_ahb_matrix_slave_port #(
    parameter int unsigned MNUM = 8
) (
    input  logic                 hclk,
    input  logic                 hresetn,
    input  logic [MNUM*32-1:0]   im_haddr,
    input  logic [MNUM*2-1:0]    im_htrans,
    input  logic [MNUM-1:0]      im_hwrite,
    input  logic [MNUM*3-1:0]    im_hsize,
    input  logic [MNUM*3-1:0]    im_hburst,
    input  logic [MNUM*4-1:0]    im_hprot,
    input  logic [MNUM*32-1:0]   im_hwdata,
    output logic [31:0]          om_hrdata,
    output logic [MNUM-1:0]      om_hready,
    output logic [1:0]           om_hresp,
    output logic [31:0]          os_haddr,
    output logic [1:0]           os_htrans,
    output logic                 os_hwrite,
    output logic [2:0]           os_hsize,
    output logic [2:0]           os_hburst,
    output logic [3:0]           os_hprot,
    output logic [31:0]          os_hwdata,
    output logic                 os_hsel,
    input  logic [31:0]          is_hrdata,
    input  logic                 is_hready,
    input  logic [1:0]           is_hresp
);

    localparam int unsigned IW = (MNUM > 1) ? $clog2(MNUM) : 1;
    localparam logic [1:0]  HT_IDLE = 2'b00;

    if ((MNUM < 1) || (MNUM > 16)) begin : g_bad_mnum
        $fatal(1, "ehl_ahb_matrix_slave_port: MNUM must be 1..16");
    end

    // Per-master views of the flattened input buses
    logic [31:0]   w_haddr  [MNUM];
    logic [1:0]    w_htrans [MNUM];
    logic [2:0]    w_hsize  [MNUM];
    logic [2:0]    w_hburst [MNUM];
    logic [3:0]    w_hprot  [MNUM];
    logic [31:0]   w_hwdata [MNUM];
    logic [MNUM-1:0] w_req;

    for (genvar m = 0; m < MNUM; m++) begin : g_unpack
        assign w_haddr[m]  = im_haddr[32*m +: 32];
        assign w_htrans[m] = im_htrans[2*m +: 2];
        assign w_hsize[m]  = im_hsize[3*m +: 3];
        assign w_hburst[m] = im_hburst[3*m +: 3];
        assign w_hprot[m]  = im_hprot[4*m +: 4];
        assign w_hwdata[m] = im_hwdata[32*m +: 32];
        // NONSEQ and SEQ both have htrans[1] set
        assign w_req[m]    = w_htrans[m][1];
    end

    logic [IW-1:0] r_last;
    logic [IW-1:0] r_grant;
    logic          r_dph_valid;
    logic [IW-1:0] r_dph_owner;

    logic          w_lock;
    logic [IW-1:0] w_rr;
    logic [IW-1:0] w_grant;
    logic [1:0]    w_gtrans;
    logic [IW-1:0] w_wd_idx;

    // Arbitration: burst lock first, else round-robin from last+1, else hold
    always_comb begin
        w_rr   = r_grant;
        // SEQ and BUSY both have htrans[0] set; they continue a burst
        w_lock = w_htrans[r_grant][0];
        // Descending scan so the nearest requester after r_last wins
        for (int off = int'(MNUM); off >= 1; off--) begin
            if (w_req[(int'(r_last) + off) % int'(MNUM)]) begin
                w_rr = IW'((int'(r_last) + off) % int'(MNUM));
            end
        end
        w_grant = w_lock ? r_grant : w_rr;
    end

    // Address-phase mux to the slave
    assign w_gtrans  = w_htrans[w_grant];
    assign os_hsel   = (w_gtrans != HT_IDLE);
    assign os_htrans = os_hsel ? w_gtrans : HT_IDLE;
    assign os_haddr  = w_haddr[w_grant];
    assign os_hwrite = im_hwrite[w_grant];
    assign os_hsize  = w_hsize[w_grant];
    assign os_hburst = w_hburst[w_grant];
    assign os_hprot  = w_hprot[w_grant];

    // Write data follows the data-phase owner; master 0 when no data phase
    assign w_wd_idx  = r_dph_valid ? r_dph_owner : '0;
    assign os_hwdata = w_hwdata[w_wd_idx];

    assign om_hrdata = is_hrdata;
    assign om_hresp  = is_hresp;

    // Per-master ready: owner waits on the slave, requesting losers are held
    always_comb begin
        om_hready = '1;
        for (int m = 0; m < int'(MNUM); m++) begin
            if (r_dph_valid && (int'(r_dph_owner) == m) && !is_hready) begin
                om_hready[m] = 1'b0;
            end
            if (w_req[m] && ((int'(w_grant) != m) || !is_hready)) begin
                om_hready[m] = 1'b0;
            end
        end
    end

    // Arbitration and data-phase state advance only when the slave is ready
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_last      <= IW'(MNUM - 1);
            r_grant     <= '0;
            r_dph_valid <= 1'b0;
            r_dph_owner <= '0;
        end else if (is_hready) begin
            r_grant     <= w_grant;
            if (w_req[w_grant]) begin
                r_last <= w_grant;
            end
            r_dph_valid <= os_hsel & os_htrans[1];
            r_dph_owner <= w_grant;
        end
    end

endmodule

// File: tb/tb_ehl_ahb_matrix_slave_port.sv
module tb_ehl_ahb_matrix_slave_port;

    localparam int MNUM = 8;
    localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, NONSEQ = 2'd2, SEQ = 2'd3;

    logic                 hclk;
    logic                 hresetn;
    logic [MNUM*32-1:0]   im_haddr;
    logic [MNUM*2-1:0]    im_htrans;
    logic [MNUM-1:0]      im_hwrite;
    logic [MNUM*3-1:0]    im_hsize;
    logic [MNUM*3-1:0]    im_hburst;
    logic [MNUM*4-1:0]    im_hprot;
    logic [MNUM*32-1:0]   im_hwdata;
    logic [31:0]          om_hrdata;
    logic [MNUM-1:0]      om_hready;
    logic [1:0]           om_hresp;
    logic [31:0]          os_haddr;
    logic [1:0]           os_htrans;
    logic                 os_hwrite;
    logic [2:0]           os_hsize;
    logic [2:0]           os_hburst;
    logic [3:0]           os_hprot;
    logic [31:0]          os_hwdata;
    logic                 os_hsel;
    logic [31:0]          is_hrdata;
    logic                 is_hready;
    logic [1:0]           is_hresp;

    ehl_ahb_matrix_slave_port #(.MNUM(MNUM)) dut (
        .hclk(hclk), .hresetn(hresetn),
        .im_haddr(im_haddr), .im_htrans(im_htrans), .im_hwrite(im_hwrite),
        .im_hsize(im_hsize), .im_hburst(im_hburst), .im_hprot(im_hprot),
        .im_hwdata(im_hwdata),
        .om_hrdata(om_hrdata), .om_hready(om_hready), .om_hresp(om_hresp),
        .os_haddr(os_haddr), .os_htrans(os_htrans), .os_hwrite(os_hwrite),
        .os_hsize(os_hsize), .os_hburst(os_hburst), .os_hprot(os_hprot),
        .os_hwdata(os_hwdata), .os_hsel(os_hsel),
        .is_hrdata(is_hrdata), .is_hready(is_hready), .is_hresp(is_hresp)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state (arbitration memory and data-phase owner)
    int mdl_last, mdl_grant, mdl_do;
    bit mdl_dv;

    typedef struct {
        logic [15:0] ht;
        logic        rdy;
        logic        exp_hsel;
        logic [1:0]  exp_htrans;
        logic [31:0] exp_haddr;
        logic [31:0] exp_hwdata;
        logic [7:0]  exp_ohr;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_defaults();
        for (int m = 0; m < MNUM; m++) begin
            im_haddr[32*m +: 32]  = 32'h4000_0000 | (32'(m) << 12);
            im_hwdata[32*m +: 32] = 32'hA000_0000 | 32'(m);
            im_htrans[2*m +: 2]   = IDLE;
            im_hsize[3*m +: 3]    = 3'd2;
            im_hburst[3*m +: 3]   = 3'd0;
            im_hprot[4*m +: 4]    = 4'h3;
        end
        im_hwrite = '0;
        is_hready = 1'b1;
        is_hresp  = 2'b00;
        is_hrdata = 32'h0;
    endtask

    task automatic set_ht(input int m, input logic [1:0] t);
        im_htrans[2*m +: 2] = t;
    endtask

    task automatic do_reset();
        @(negedge hclk);
        hresetn = 1'b0;
        set_defaults();
        #2;
        chk("rst_hsel",   32'(os_hsel), 32'h0);
        chk("rst_htrans", 32'(os_htrans), 32'h0);
        chk("rst_hready", 32'(om_hready), 32'hFF);
        chk("rst_haddr",  os_haddr, im_haddr[31:0]);
        @(negedge hclk);
        hresetn = 1'b1;
        mdl_last  = MNUM - 1;
        mdl_grant = 0;
        mdl_dv    = 1'b0;
        mdl_do    = 0;
    endtask

    function automatic logic [1:0] tr(input int m);
        return im_htrans[2*m +: 2];
    endfunction

    // Lock holder keeps the bus; else nearest requester after last; else hold
    function automatic int model_pick();
        int best = -1;
        int bestd = MNUM + 1;
        if (tr(mdl_grant) == SEQ || tr(mdl_grant) == BUSY) return mdl_grant;
        for (int m = 0; m < MNUM; m++) begin
            if (tr(m) == NONSEQ || tr(m) == SEQ) begin
                int d = (m - mdl_last - 1 + 2 * MNUM) % MNUM;
                if (d < bestd) begin
                    bestd = d;
                    best  = m;
                end
            end
        end
        return (best < 0) ? mdl_grant : best;
    endfunction

    function automatic logic [1:0] rand_trans();
        int r = $urandom_range(0, 9);
        if (r <= 4) return IDLE;
        if (r <= 6) return NONSEQ;
        if (r <= 8) return SEQ;
        return BUSY;
    endfunction

    initial begin
        logic [7:0]  exp_ohr;
        logic [31:0] exp_wd;
        logic [10:0] exp_ctl;
        int          g;
        bit          req;

        hresetn = 1'b0;
        set_defaults();

        // ---------------- table-driven vectors from reset ----------------
        tbl[0] = '{16'h0000, 1'b1, 1'b0, 2'd0, 32'h4000_0000, 32'hA000_0000, 8'hFF};
        tbl[1] = '{16'h0808, 1'b1, 1'b1, 2'd2, 32'h4000_1000, 32'hA000_0000, 8'hDF};
        tbl[2] = '{16'h0800, 1'b1, 1'b1, 2'd2, 32'h4000_5000, 32'hA000_0001, 8'hFF};
        tbl[3] = '{16'h2002, 1'b1, 1'b1, 2'd2, 32'h4000_6000, 32'hA000_0005, 8'hFE};
        tbl[4] = '{16'h8002, 1'b1, 1'b1, 2'd2, 32'h4000_7000, 32'hA000_0006, 8'hFE};
        tbl[5] = '{16'h000A, 1'b1, 1'b1, 2'd2, 32'h4000_0000, 32'hA000_0007, 8'hFD};
        tbl[6] = '{16'h0000, 1'b1, 1'b0, 2'd0, 32'h4000_0000, 32'hA000_0000, 8'hFF};
        tbl[7] = '{16'h0002, 1'b1, 1'b1, 2'd2, 32'h4000_0000, 32'hA000_0000, 8'hFF};

        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge hclk);
            im_htrans = tbl[i].ht;
            is_hready = tbl[i].rdy;
            #2;
            chk($sformatf("tbl%0d_hsel", i),   32'(os_hsel),   32'(tbl[i].exp_hsel));
            chk($sformatf("tbl%0d_htrans", i), 32'(os_htrans), 32'(tbl[i].exp_htrans));
            chk($sformatf("tbl%0d_haddr", i),  os_haddr,       tbl[i].exp_haddr);
            chk($sformatf("tbl%0d_hwdata", i), os_hwdata,      tbl[i].exp_hwdata);
            chk($sformatf("tbl%0d_hready", i), 32'(om_hready), 32'(tbl[i].exp_ohr));
        end

        // ---------------- M3 single write ----------------
        do_reset();
        @(negedge hclk);
        set_ht(3, NONSEQ);
        im_haddr[32*3 +: 32] = 32'h0000_1000;
        im_hwrite[3] = 1'b1;
        #2;
        chk("wr_haddr",  os_haddr, 32'h0000_1000);
        chk("wr_hsel",   32'(os_hsel), 32'h1);
        chk("wr_hwrite", 32'(os_hwrite), 32'h1);
        @(negedge hclk);
        set_ht(3, IDLE);
        im_hwdata[32*3 +: 32] = 32'hA5A5_A5A5;
        #2;
        chk("wr_hwdata", os_hwdata, 32'hA5A5_A5A5);
        chk("wr_hsel_idle", 32'(os_hsel), 32'h0);

        // ---------------- M2 INCR4 burst lock vs M0 ----------------
        do_reset();
        @(negedge hclk);
        set_ht(2, NONSEQ);
        #2;
        chk("bst_first_addr", os_haddr, 32'h4000_2000);
        begin
            logic [1:0] beats [4];
            beats[0] = SEQ; beats[1] = BUSY; beats[2] = SEQ; beats[3] = SEQ;
            for (int b = 0; b < 4; b++) begin
                @(negedge hclk);
                set_ht(2, beats[b]);
                set_ht(0, NONSEQ);
                #2;
                chk($sformatf("bst%0d_haddr", b),  os_haddr, 32'h4000_2000);
                chk($sformatf("bst%0d_htrans", b), 32'(os_htrans), 32'(beats[b]));
                chk($sformatf("bst%0d_m0rdy", b),  32'(om_hready[0]), 32'h0);
                chk($sformatf("bst%0d_m2rdy", b),  32'(om_hready[2]), 32'h1);
            end
        end
        @(negedge hclk);
        set_ht(2, IDLE);
        #2;
        chk("bst_end_haddr", os_haddr, 32'h4000_0000);
        chk("bst_end_hready", 32'(om_hready), 32'hFF);

        // ---------------- wait states during M4 data phase ----------------
        do_reset();
        @(negedge hclk);
        set_ht(4, NONSEQ);
        set_ht(6, NONSEQ);
        #2;
        chk("ws_grant4", os_haddr, 32'h4000_4000);
        chk("ws_m6_held", 32'(om_hready), 32'hBF);
        for (int c = 0; c < 2; c++) begin
            @(negedge hclk);
            set_ht(4, IDLE);
            is_hready = 1'b0;
            is_hrdata = 32'hDEAD_BEEF;
            #2;
            chk($sformatf("ws%0d_hready", c), 32'(om_hready), 32'hAF);
            chk($sformatf("ws%0d_haddr", c),  os_haddr, 32'h4000_6000);
            chk($sformatf("ws%0d_hrdata", c), om_hrdata, 32'hDEAD_BEEF);
        end
        @(negedge hclk);
        is_hready = 1'b1;
        #2;
        chk("ws_end_haddr", os_haddr, 32'h4000_6000);
        chk("ws_end_hready", 32'(om_hready), 32'hFF);

        // ---------------- two-cycle ERROR response ----------------
        do_reset();
        @(negedge hclk);
        set_ht(3, NONSEQ);
        #2;
        @(negedge hclk);
        set_ht(3, IDLE);
        is_hresp  = 2'b01;
        is_hready = 1'b0;
        #2;
        chk("err1_hresp", 32'(om_hresp), 32'h1);
        chk("err1_rdy3",  32'(om_hready[3]), 32'h0);
        @(negedge hclk);
        is_hready = 1'b1;
        #2;
        chk("err2_hresp", 32'(om_hresp), 32'h1);
        chk("err2_rdy3",  32'(om_hready[3]), 32'h1);

        // ---------------- randomized traffic vs reference model ----------------
        do_reset();
        for (int c = 0; c < 600; c++) begin
            @(negedge hclk);
            for (int m = 0; m < MNUM; m++) begin
                im_htrans[2*m +: 2]   = rand_trans();
                im_haddr[32*m +: 32]  = $urandom;
                im_hwdata[32*m +: 32] = $urandom;
                im_hsize[3*m +: 3]    = 3'($urandom_range(0, 7));
                im_hburst[3*m +: 3]   = 3'($urandom_range(0, 7));
                im_hprot[4*m +: 4]    = 4'($urandom_range(0, 15));
                im_hwrite[m]          = 1'($urandom_range(0, 1));
            end
            is_hready = ($urandom_range(0, 3) != 0);
            is_hrdata = $urandom;
            is_hresp  = 2'($urandom_range(0, 1));
            #2;
            g = model_pick();
            exp_wd  = mdl_dv ? im_hwdata[32*mdl_do +: 32] : im_hwdata[31:0];
            exp_ctl = {im_hwrite[g], im_hsize[3*g +: 3], im_hburst[3*g +: 3], im_hprot[4*g +: 4]};
            for (int m = 0; m < MNUM; m++) begin
                req = (tr(m) == NONSEQ) || (tr(m) == SEQ);
                exp_ohr[m] = !((mdl_dv && mdl_do == m && !is_hready) ||
                               (req && (m != g || !is_hready)));
            end
            chk("rnd_haddr",  os_haddr, im_haddr[32*g +: 32]);
            chk("rnd_htrans", 32'(os_htrans), 32'(tr(g)));
            chk("rnd_hsel",   32'(os_hsel), 32'(tr(g) != IDLE));
            chk("rnd_ctl",    32'({os_hwrite, os_hsize, os_hburst, os_hprot}), 32'(exp_ctl));
            chk("rnd_hwdata", os_hwdata, exp_wd);
            chk("rnd_hready", 32'(om_hready), 32'(exp_ohr));
            chk("rnd_rsp",    {om_hrdata[29:0], om_hresp}, {is_hrdata[29:0], is_hresp});
            if (is_hready) begin
                mdl_dv = (tr(g) == NONSEQ) || (tr(g) == SEQ);
                mdl_do = g;
                if (tr(g) == NONSEQ || tr(g) == SEQ) mdl_last = g;
                mdl_grant = g;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
